// File: rtl/dmem_pkg.sv
// Shared access-size encoding, FSM state codes, latency limits and byte-lane
// helpers for the MIPS data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned LAT_MIN = 32'd1;
  localparam int unsigned LAT_MAX = 32'd15;
  localparam int unsigned CNT_W   = 32'd4;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size_e'(size))
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size_e'(size))
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Little-endian byte-lane formatter: store alignment with lane mask, and load
// lane extraction with sign/zero extension. Purely combinational.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wdata_al,
  output logic [3:0]  wmask,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: replicate sub-word data into every lane, the mask selects which are written.
  always_comb begin
    wmask = lane_mask(size, addr_lo);
    case (size_e'(size))
      SZ_BYTE: wdata_al = {4{wdata[7:0]}};
      SZ_HALF: wdata_al = {2{wdata[15:0]}};
      default: wdata_al = wdata;
    endcase
  end

  // Load side: pick the addressed lane(s) and extend to a full word.
  always_comb begin
    byte_s = rword[{addr_lo, 3'b000} +: 8];
    half_s = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size_e'(size))
      SZ_BYTE: rdata_ext = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
      SZ_HALF: rdata_ext = {{16{half_s[15] & ~is_unsigned}}, half_s};
      default: rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory for the MIPS core: byte/half/word access, error detection and a
// valid/ready request/response handshake with a configurable wait-state count.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  // LATENCY outside 1..15 is clamped so the 4-bit wait counter cannot wrap.
  localparam int unsigned LAT_C = (LATENCY < LAT_MIN) ? LAT_MIN :
                                  ((LATENCY > LAT_MAX) ? LAT_MAX : LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_C - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [31:0]      mem_r [DEPTH];
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_err_r;

  logic             accept_s;
  logic             oor_s;
  logic             err_s;
  logic             we_s;
  logic [AW-1:0]    idx_s;
  logic [31:0]      rword_s;
  logic [31:0]      rdata_nxt_s;
  logic [31:0]      wdata_al_s;
  logic [31:0]      rdata_ext_s;
  logic [3:0]       wmask_s;

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  dmem_lane_fmt u_fmt (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .addr_lo     (req_addr[1:0]),
    .wdata       (req_wdata),
    .rword       (rword_s),
    .wdata_al    (wdata_al_s),
    .wmask       (wmask_s),
    .rdata_ext   (rdata_ext_s)
  );

  // Request decode; the range check uses all of addr[31:2] so high bits never alias.
  always_comb begin
    accept_s = req_valid && req_ready_r && (state_r == IDLE);
    oor_s    = (req_addr[31:2] >= 30'(DEPTH));
    err_s    = (req_size == 2'b11) || misaligned(req_size, req_addr[1:0]) || oor_s;
    idx_s    = req_addr[AW+1:2];
    rword_s  = oor_s ? 32'h0000_0000 : mem_r[idx_s];
    we_s     = rst_n && accept_s && req_we && !err_s;
    if (err_s || req_we) begin
      rdata_nxt_s = 32'h0000_0000;
    end else begin
      rdata_nxt_s = rdata_ext_s;
    end
  end

  // RAM write with per-lane enables; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_al_s[8*i +: 8];
        end
      end
    end
  end

  // Handshake FSM, wait counter and registered response fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rsp_rdata_r <= rdata_nxt_s;
            rsp_err_r   <= err_s;
            req_ready_r <= 1'b0;
            if (LAT_C > 32'd1) begin
              state_r <= BUSY;
              cnt_r   <= CNT_LOAD;
            end else begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_r == CNT_ONE) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: instance 0 runs LATENCY=1, instance 1 LATENCY=4.
// Stimulus pushes expected {err, rdata}; a negedge monitor pops on each response handshake.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [32:0] exp;
  } vec_t;
  localparam int NB = 8;
  vec_t bb [NB];

  dmem_ctrl #(.DEPTH(128), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_ctrl #(.DEPTH(128), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [32:0] e);
    if (k == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic check_rsp(input int k);
    logic [32:0] a;
    logic [32:0] e;
    a = {rsp_err[k], rsp_rdata[k]};
    if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
    else if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    else begin
      checks++;
      errors++;
      $display("FAIL unexpected_rsp dut=%0d actual=%h required=none", k, a);
      return;
    end
    chk($sformatf("rsp dut=%0d", k), a, e);
  endtask

  // Response monitor: compare each handshaken response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rsp_valid[0] === 1'b1 && rsp_ready[0] === 1'b1) check_rsp(0);
      if (rsp_valid[1] === 1'b1 && rsp_ready[1] === 1'b1) check_rsp(1);
    end
  end

  task automatic wait_accept(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut=%0d actual=%b required=1", k, req_ready[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid[k] !== 1'b1 && n < 50);
  endtask

  task automatic drive(input int k, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we[k] = we;
    req_size[k] = sz;
    req_unsigned[k] = uns;
    req_addr[k] = addr;
    req_wdata[k] = wdata;
  endtask

  task automatic xact(input int k, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    push(k, {exp_err, exp_rd});
    drive(k, we, sz, uns, addr, wdata);
    rsp_ready[k] = 1'b1;
    req_valid[k] = 1'b1;
    wait_accept(k);
    req_valid[k] = 1'b0;
    wait_rsp(k, n);
    chk($sformatf("latency dut=%0d addr=%h", k, addr), 33'(n), (k == 0) ? 33'd1 : 33'd4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int prev;
    logic rr_bad;

    bb[0] = '{1'b1, W, 1'b0, 32'h0000_0104, 32'h0A0B_0C0D, 33'h0_0000_0000};
    bb[1] = '{1'b1, B, 1'b0, 32'h0000_0105, 32'hFFFF_FF77, 33'h0_0000_0000};
    bb[2] = '{1'b0, W, 1'b0, 32'h0000_0104, 32'h0000_0000, 33'h0_0A0B_770D};
    bb[3] = '{1'b1, H, 1'b0, 32'h0000_0106, 32'h0000_BEEF, 33'h0_0000_0000};
    bb[4] = '{1'b0, W, 1'b0, 32'h0000_0104, 32'h0000_0000, 33'h0_BEEF_770D};
    bb[5] = '{1'b0, H, 1'b1, 32'h0000_0106, 32'h0000_0000, 33'h0_0000_BEEF};
    bb[6] = '{1'b0, B, 1'b0, 32'h0000_0105, 32'h0000_0000, 33'h0_0000_0077};
    bb[7] = '{1'b0, B, 1'b0, 32'h0000_0107, 32'h0000_0000, 33'h0_FFFF_FFBE};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b0;
      drive(k, 1'b0, W, 1'b0, 32'h0, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", {32'h0, req_ready[k]}, 33'h1);
      chk("reset_rsp_valid", {32'h0, rsp_valid[k]}, 33'h0);
      chk("reset_rsp_fields", {rsp_err[k], rsp_rdata[k]}, 33'h0);
    end
    @(posedge clk);
    #1;

    // LATENCY=1: basic store/load, sub-word lanes and extension
    xact(0, 1'b1, W, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact(0, 1'b0, W, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xact(0, 1'b1, B, 1'b0, 32'h41, 32'h1234_565A, 32'h0, 1'b0);
    xact(0, 1'b0, W, 1'b0, 32'h40, 32'h0, 32'hDEAD_5AEF, 1'b0);
    xact(0, 1'b0, B, 1'b0, 32'h43, 32'h0, 32'hFFFF_FFDE, 1'b0);
    xact(0, 1'b0, B, 1'b1, 32'h43, 32'h0, 32'h0000_00DE, 1'b0);
    xact(0, 1'b0, H, 1'b0, 32'h42, 32'h0, 32'hFFFF_DEAD, 1'b0);
    xact(0, 1'b0, H, 1'b1, 32'h42, 32'h0, 32'h0000_DEAD, 1'b0);
    xact(0, 1'b0, H, 1'b0, 32'h40, 32'h0, 32'h0000_5AEF, 1'b0);
    xact(0, 1'b0, B, 1'b0, 32'h40, 32'h0, 32'hFFFF_FFEF, 1'b0);
    xact(0, 1'b0, W, 1'b1, 32'h40, 32'h0, 32'hDEAD_5AEF, 1'b0);
    // errors: misaligned, illegal size, out of range; memory must be untouched
    xact(0, 1'b0, H, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1);
    xact(0, 1'b1, H, 1'b0, 32'h41, 32'h0000_1111, 32'h0, 1'b1);
    xact(0, 1'b0, W, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1);
    xact(0, 1'b0, X, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
    xact(0, 1'b1, X, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xact(0, 1'b0, W, 1'b0, 32'h40, 32'h0, 32'hDEAD_5AEF, 1'b0);
    xact(0, 1'b1, W, 1'b0, 32'h0, 32'h1357_9BDF, 32'h0, 1'b0);
    xact(0, 1'b1, W, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xact(0, 1'b0, W, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    xact(0, 1'b0, W, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
    xact(0, 1'b0, W, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 1'b0);
    xact(0, 1'b1, W, 1'b0, 32'h1FC, 32'hA5A5_A5A5, 32'h0, 1'b0);
    xact(0, 1'b0, W, 1'b0, 32'h1FC, 32'h0, 32'hA5A5_A5A5, 1'b0);
    xact(0, 1'b1, B, 1'b0, 32'h43, 32'h0000_0080, 32'h0, 1'b0);
    xact(0, 1'b0, W, 1'b0, 32'h40, 32'h0, 32'h80AD_5AEF, 1'b0);

    // LATENCY=1 back-to-back: req_valid held high, one accept every 2 cycles
    rsp_ready[0] = 1'b1;
    prev = 0;
    for (int i = 0; i < NB; i++) begin
      drive(0, bb[i].we, bb[i].sz, bb[i].uns, bb[i].addr, bb[i].wdata);
      req_valid[0] = 1'b1;
      push(0, bb[i].exp);
      n = 0;
      @(negedge clk);
      while (req_ready[0] !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      acc = cyc;
      if (i > 0) chk($sformatf("b2b_spacing i=%0d", i), 33'(acc - prev), 33'd2);
      prev = acc;
      @(posedge clk);
      #1;
    end
    req_valid[0] = 1'b0;
    wait_rsp(0, n);
    @(posedge clk);
    #1;

    // LATENCY=4 basic pair
    xact(1, 1'b1, W, 1'b0, 32'h80, 32'h1234_5678, 32'h0, 1'b0);
    xact(1, 1'b0, W, 1'b0, 32'h80, 32'h0, 32'h1234_5678, 1'b0);

    // LATENCY=4 with rsp_ready held low; a second request waits behind it
    push(1, {1'b0, 32'h0000_1234});
    drive(1, 1'b0, H, 1'b1, 32'h82, 32'h0);
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1;
    wait_accept(1);
    drive(1, 1'b0, B, 1'b0, 32'h83, 32'h0);
    push(1, {1'b0, 32'h0000_0012});
    rr_bad = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (req_ready[1] !== 1'b0) rr_bad = 1'b1;
    end while (rsp_valid[1] !== 1'b1 && n < 50);
    chk("hold_latency", 33'(n), 33'd4);
    for (int h = 0; h < 3; h++) begin
      if (h > 0) @(negedge clk);
      chk($sformatf("hold_data h=%0d", h), {rsp_err[1], rsp_rdata[1]}, {1'b0, 32'h0000_1234});
      chk($sformatf("hold_valid h=%0d", h), {32'h0, rsp_valid[1]}, 33'h1);
      if (req_ready[1] !== 1'b0) rr_bad = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    if (req_ready[1] !== 1'b0) rr_bad = 1'b1;
    chk("hold_req_ready_low", {32'h0, rr_bad}, 33'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reaccept_ready", {32'h0, req_ready[1]}, 33'h1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, n);
    chk("second_latency", 33'(n), 33'd4);
    @(posedge clk);
    #1;

    // Reset while BUSY after a store: response dropped, store kept
    drive(1, 1'b1, W, 1'b0, 32'h10, 32'hCAFE_F00D);
    req_valid[1] = 1'b1;
    wait_accept(1);
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy_rsp_valid", {32'h0, rsp_valid[1]}, 33'h0);
    chk("rst_busy_req_ready", {32'h0, req_ready[1]}, 33'h1);
    @(posedge clk);
    #1;
    xact(1, 1'b0, W, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);

    repeat (3) @(posedge clk);
    chk("q0_drained", 33'(exp_q0.size()), 33'd0);
    chk("q1_drained", 33'(exp_q1.size()), 33'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
